// File: rtl/usb_fs_pkg.sv
// ---------------------------------------------------------------------------
// usb_fs_pkg
// Shared definitions for the full-speed USB OUT drain path: scheduler state
// encoding, endpoint number width and the downstream byte tuple layout.
// ---------------------------------------------------------------------------
package usb_fs_pkg;

    // Drain scheduler states.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } sched_state_t;

    localparam int EP_NUM_W = 4;
    localparam int TUPLE_W  = 14;

    // One downstream entry: {setup, last, ep[3:0], data[7:0]}.
    typedef struct packed {
        logic                setup;
        logic                last;
        logic [EP_NUM_W-1:0] ep;
        logic [7:0]          data;
    } dout_tuple_t;

endpackage

// File: rtl/usb_fs_skid_fifo2.sv
// ---------------------------------------------------------------------------
// usb_fs_skid_fifo2
// Two-entry FIFO used as the output skid buffer of the OUT drain scheduler.
// A push and a pop may happen in the same cycle even when the FIFO is full.
// The head is forced to zero while empty so the downstream fields read zero
// whenever nothing is valid.
//
// Ports:
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_push, i_din    : write strobe and entry
//   i_pop            : remove the head (ignored while empty)
//   o_dout, o_valid  : head entry and non-empty flag
//   o_count          : number of stored entries (0..2)
// ---------------------------------------------------------------------------
module usb_fs_skid_fifo2
    import usb_fs_pkg::*;
#(
    parameter int WIDTH = TUPLE_W
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // A simultaneous pop frees the slot the push needs when full.
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_dout  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/usb_fs_out_drain_sched.sv
// ---------------------------------------------------------------------------
// usb_fs_out_drain_sched
// Round-robin drain of the OUT protocol engine's per-endpoint packet buffers
// into one valid/ready byte stream. One endpoint is granted at a time and
// keeps the grant until its packet's last byte is captured. Read strobes
// account for the engine's one-cycle registered read latency, and a 2-entry
// skid FIFO absorbs downstream backpressure.
//
// Ports:
//   i_clk, i_reset_n          : clock, synchronous active-low reset
//   i_ep_enable               : per-endpoint drain enable (checked at arbitration only)
//   i_out_ep_data_avail       : endpoint has undrained payload bytes
//   i_out_ep_setup            : current packet on endpoint arrived via SETUP
//   i_out_ep_data             : byte read by the previous cycle's get
//   o_out_ep_data_get         : one-hot read strobe to the engine
//   o_dout_valid/i_dout_ready : downstream handshake
//   o_dout_data/ep/setup/last : downstream byte and its tags
//   o_busy                    : grant held, read in flight or bytes buffered
// ---------------------------------------------------------------------------
module usb_fs_out_drain_sched
    import usb_fs_pkg::*;
#(
    parameter int NUM_OUT_EPS = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [NUM_OUT_EPS-1:0] i_ep_enable,
    input  logic [NUM_OUT_EPS-1:0] i_out_ep_data_avail,
    input  logic [NUM_OUT_EPS-1:0] i_out_ep_setup,
    input  logic [7:0]             i_out_ep_data,
    output logic [NUM_OUT_EPS-1:0] o_out_ep_data_get,
    output logic                   o_dout_valid,
    input  logic                   i_dout_ready,
    output logic [7:0]             o_dout_data,
    output logic [EP_NUM_W-1:0]    o_dout_ep,
    output logic                   o_dout_setup,
    output logic                   o_dout_last,
    output logic                   o_busy
);

    sched_state_t            r_state;
    sched_state_t            w_state_next;
    logic [EP_NUM_W-1:0]     r_grant;
    logic [EP_NUM_W-1:0]     r_rr_ptr;
    logic                    r_grant_setup;
    logic                    r_inflight;

    logic [NUM_OUT_EPS-1:0]  w_req;
    logic [NUM_OUT_EPS-1:0]  w_after;
    logic [NUM_OUT_EPS-1:0]  w_pick_oh;
    logic [NUM_OUT_EPS-1:0]  w_grant_oh;
    logic [EP_NUM_W-1:0]     w_pick;
    logic                    w_pick_setup;
    logic                    w_grant_avail;
    logic                    w_get;
    logic                    w_pop;
    logic                    w_credit;
    logic                    w_fifo_valid;
    logic [1:0]              w_fifo_count;
    dout_tuple_t             w_push_tuple;
    dout_tuple_t             w_head;

    // Lowest requester above the pointer wins; if none, wrap to the lowest
    // requester overall. Later assignments in the loops override earlier ones.
    function automatic logic [EP_NUM_W-1:0] rr_pick(
        input logic [NUM_OUT_EPS-1:0] req,
        input logic [NUM_OUT_EPS-1:0] after
    );
        logic [EP_NUM_W-1:0]    pick;
        logic [NUM_OUT_EPS-1:0] hi;
        pick = '0;
        hi   = req & after;
        for (int i = NUM_OUT_EPS - 1; i >= 0; i--) begin
            if (req[i]) pick = EP_NUM_W'(i);
        end
        for (int i = NUM_OUT_EPS - 1; i >= 0; i--) begin
            if (hi[i]) pick = EP_NUM_W'(i);
        end
        return pick;
    endfunction

    assign w_req  = i_out_ep_data_avail & i_ep_enable;
    assign w_pick = rr_pick(w_req, w_after);

    // Per-endpoint decodes avoid indexing narrow vectors with the 4-bit number.
    for (genvar gi = 0; gi < NUM_OUT_EPS; gi++) begin : g_ep
        assign w_after[gi]    = (EP_NUM_W'(gi) > r_rr_ptr);
        assign w_pick_oh[gi]  = (w_pick == EP_NUM_W'(gi));
        assign w_grant_oh[gi] = (r_grant == EP_NUM_W'(gi));
    end

    assign w_pick_setup  = |(i_out_ep_setup & w_pick_oh);
    assign w_grant_avail = |(i_out_ep_data_avail & w_grant_oh);

    // Avail seen in the capture cycle already reflects the read in flight,
    // so a low avail marks the captured byte as the packet's last.
    assign w_push_tuple = {r_grant_setup, ~w_grant_avail, r_grant, i_out_ep_data};

    assign w_pop = w_fifo_valid & i_dout_ready;
    // A byte leaving this cycle frees a slot, which keeps 1 byte/cycle flowing.
    assign w_credit = (({1'b0, w_fifo_count} + {2'b00, r_inflight}) <
                       (3'd2 + {2'b00, w_pop}));

    always_comb begin
        w_state_next = r_state;
        w_get        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                w_get = w_grant_avail && w_credit;
                if (r_inflight && w_push_tuple.last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_setup <= 1'b0;
            r_rr_ptr      <= EP_NUM_W'(NUM_OUT_EPS - 1);
            r_inflight    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_get;
            if ((r_state == ST_IDLE) && (|w_req)) begin
                r_grant       <= w_pick;
                r_grant_setup <= w_pick_setup;
            end
            if (r_inflight && w_push_tuple.last) begin
                r_rr_ptr <= r_grant;
            end
        end
    end

    usb_fs_skid_fifo2 #(
        .WIDTH (TUPLE_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (r_inflight),
        .i_din     (w_push_tuple),
        .i_pop     (w_pop),
        .o_dout    (w_head),
        .o_valid   (w_fifo_valid),
        .o_count   (w_fifo_count)
    );

    assign o_out_ep_data_get = w_get ? w_grant_oh : '0;
    assign o_dout_valid      = w_fifo_valid;
    assign o_dout_data       = w_head.data;
    assign o_dout_ep         = w_head.ep;
    assign o_dout_setup      = w_head.setup;
    assign o_dout_last       = w_head.last;
    assign o_busy            = (r_state == ST_STREAM) | r_inflight | (w_fifo_count != 2'd0);

endmodule

// File: tb/tb_usb_fs_out_drain_sched.sv
// ---------------------------------------------------------------------------
// tb_usb_fs_out_drain_sched
// Self-checking bench for the OUT drain scheduler with two endpoints. A
// simple engine model serves bytes one cycle after each get; the expected
// downstream stream is derived from the loaded packets and the round-robin
// rule, then compared against what the DUT delivers.
// ---------------------------------------------------------------------------
module tb_usb_fs_out_drain_sched;
    localparam int N = 2;

    typedef struct {
        logic [7:0] d;
        logic [3:0] ep;
        logic       s;
        logic       l;
        int         c;
    } rx_t;

    typedef struct {
        int c;
        int e;
    } get_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic [N-1:0] ep_enable;
    logic [N-1:0] avail;
    logic [N-1:0] setup_in;
    logic [7:0]   pe_data;
    logic [N-1:0] get;
    logic         dout_valid;
    logic         dout_ready;
    logic [7:0]   dout_data;
    logic [3:0]   dout_ep;
    logic         dout_setup;
    logic         dout_last;
    logic         busy;

    usb_fs_out_drain_sched #(
        .NUM_OUT_EPS (N)
    ) dut (
        .i_clk               (clk),
        .i_reset_n           (reset_n),
        .i_ep_enable         (ep_enable),
        .i_out_ep_data_avail (avail),
        .i_out_ep_setup      (setup_in),
        .i_out_ep_data       (pe_data),
        .o_out_ep_data_get   (get),
        .o_dout_valid        (dout_valid),
        .i_dout_ready        (dout_ready),
        .o_dout_data         (dout_data),
        .o_dout_ep           (dout_ep),
        .o_dout_setup        (dout_setup),
        .o_dout_last         (dout_last),
        .o_busy              (busy)
    );

    // ---------------- engine model ----------------
    int         pe_ptr [N];
    int         pe_len [N];
    logic [7:0] pe_mem [N][512];
    logic       pe_setup [N];

    always @(posedge clk) begin
        for (int e = 0; e < N; e++) begin
            if (get[e] === 1'b1) begin
                pe_data   <= pe_mem[e][pe_ptr[e] % 512];
                pe_ptr[e] <= pe_ptr[e] + 1;
            end
        end
    end

    always_comb begin
        avail    = '0;
        setup_in = '0;
        for (int e = 0; e < N; e++) begin
            avail[e]    = (pe_ptr[e] < pe_len[e]);
            setup_in[e] = pe_setup[e];
        end
    end

    // ---------------- bookkeeping ----------------
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    rx_t         rx[$];
    get_t        gets[$];
    rx_t         expq[$];
    bit          want_ready = 1'b1;
    bit          rnd_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [13:0] prev_tup = '0;
    int          stab_viol = 0;
    int          multi_viol = 0;
    int          under_viol = 0;
    int          model_rr;
    logic [7:0]  pkt [N][$];
    logic        pkt_setup [N];

    // One clock: apply ready, sample outputs 1 ns after the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        dout_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : want_ready;
        #1;
        if (prev_stall && (!dout_valid ||
            {dout_setup, dout_last, dout_ep, dout_data} !== prev_tup)) stab_viol++;
        prev_stall = dout_valid && !dout_ready;
        prev_tup   = {dout_setup, dout_last, dout_ep, dout_data};
        if ($countones(get) > 1) multi_viol++;
        if ((get & ~avail) != '0) under_viol++;
        for (int e = 0; e < N; e++) begin
            if (get[e]) gets.push_back('{c: cyc, e: e});
        end
        if (dout_valid && dout_ready)
            rx.push_back('{d: dout_data, ep: dout_ep, s: dout_setup, l: dout_last, c: cyc});
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_rx(input int n, input int budget, output bit to);
        int i;
        i = 0;
        while (rx.size() < n && i < budget) begin
            tick();
            i++;
        end
        to = (rx.size() < n);
    endtask

    task automatic clear();
        rx.delete();
        gets.delete();
    endtask

    task automatic load(input int e, input int n, input logic [7:0] first,
                        input logic stp, input bit rnd);
        logic [7:0] b;
        pkt[e].delete();
        for (int k = 0; k < n; k++) begin
            b = rnd ? 8'($urandom) : first + 8'(k);
            pe_mem[e][(pe_ptr[e] + k) % 512] = b;
            pkt[e].push_back(b);
        end
        pkt_setup[e] = stp;
        pe_setup[e]  = stp;
        pe_len[e]    = pe_ptr[e] + n;
    endtask

    function automatic int rr_next(input int ptr, input bit [N-1:0] has);
        for (int k = 1; k <= N; k++) begin
            int e;
            e = (ptr + k) % N;
            if (has[e]) return e;
        end
        return -1;
    endfunction

    // Packets loaded together are served whole, in round-robin order after the
    // endpoint that finished most recently.
    task automatic build_expected(input bit [N-1:0] has_in);
        bit [N-1:0] has;
        int         e;
        has = has_in;
        expq.delete();
        while (has != '0) begin
            e = rr_next(model_rr, has);
            for (int k = 0; k < pkt[e].size(); k++)
                expq.push_back('{d: pkt[e][k], ep: 4'(e), s: pkt_setup[e],
                                 l: (k == pkt[e].size() - 1), c: 0});
            has[e]   = 1'b0;
            model_rr = e;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit to;
        reset_n   = 1'b0;
        ep_enable = 2'b11;
        model_rr  = N - 1;
        load(0, 2, 8'hA0, 1'b0, 1'b0);
        load(1, 2, 8'hB0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({get, dout_valid, busy} !== '0) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: get=%b valid=%b busy=%b want all 0", i, get, dout_valid, busy);
            end
            n_cmp++;
            if ({dout_data, dout_ep, dout_setup, dout_last} !== 14'h0) begin
                n_fail++;
                $display("FAIL reset_dout[%0d]: got %h want 0", i, {dout_data, dout_ep, dout_setup, dout_last});
            end
        end
        clear();
        build_expected(2'b11);
        reset_n = 1'b1;
        wait_rx(4, 40, to);
        n_cmp++;
        if (to || gets.size() == 0 || gets[0].e != 0) begin
            n_fail++;
            $display("FAIL reset_first_get: timeout=%0d gets=%0d first_ep=%0d want ep0", to, gets.size(),
                     (gets.size() > 0) ? gets[0].e : -1);
        end
        for (int k = 0; k < expq.size() && k < rx.size(); k++) begin
            n_cmp++;
            if (rx[k].d !== expq[k].d || rx[k].ep !== expq[k].ep || rx[k].l !== expq[k].l) begin
                n_fail++;
                $display("FAIL reset_stream[%0d]: got d=%h ep=%0d l=%b want d=%h ep=%0d l=%b", k,
                         rx[k].d, rx[k].ep, rx[k].l, expq[k].d, expq[k].ep, expq[k].l);
            end
        end
        $display("reset: %0d bytes after release, first ep %0d", rx.size(), (rx.size() > 0) ? rx[0].ep : 4'hF);
    endtask

    task automatic test_single();
        int lc;
        run(3);
        clear();
        want_ready = 1'b1;
        load(0, 8, 8'h10, 1'b0, 1'b0);
        build_expected(2'b01);
        lc = cyc;
        run(14);
        n_cmp++;
        if (rx.size() != 8 || gets.size() != 8) begin
            n_fail++;
            $display("FAIL single_count: got rx=%0d gets=%0d want 8/8", rx.size(), gets.size());
        end
        for (int k = 0; k < gets.size(); k++) begin
            n_cmp++;
            if (gets[k].e != 0) begin
                n_fail++;
                $display("FAIL single_get_ep[%0d]: got %0d want 0", k, gets[k].e);
            end
        end
        for (int k = 0; k < rx.size() && k < 8; k++) begin
            n_cmp++;
            if (rx[k].d !== 8'h10 + 8'(k) || rx[k].ep !== 4'd0 || rx[k].s !== 1'b0 ||
                rx[k].l !== (k == 7) || rx[k].c != lc + 3 + k) begin
                n_fail++;
                $display("FAIL single_byte[%0d]: got d=%h ep=%0d s=%b l=%b cyc=%0d want d=%h ep=0 s=0 l=%b cyc=%0d",
                         k, rx[k].d, rx[k].ep, rx[k].s, rx[k].l, rx[k].c, 8'h10 + 8'(k), (k == 7), lc + 3 + k);
            end
        end
        $display("single: %0d bytes, first at load+%0d", rx.size(), (rx.size() > 0) ? rx[0].c - lc : -1);
    endtask

    task automatic test_backpressure();
        bit to;
        clear();
        want_ready = 1'b0;
        load(0, 8, 8'h20, 1'b0, 1'b0);
        build_expected(2'b01);
        run(10);
        n_cmp++;
        if (gets.size() != 2 || rx.size() != 0) begin
            n_fail++;
            $display("FAIL bp_stall: got gets=%0d rx=%0d want 2/0", gets.size(), rx.size());
        end
        n_cmp++;
        if (dout_valid !== 1'b1 || dout_data !== 8'h20) begin
            n_fail++;
            $display("FAIL bp_head: got valid=%b data=%h want 1/20", dout_valid, dout_data);
        end
        want_ready = 1'b1;
        wait_rx(8, 30, to);
        run(3);
        n_cmp++;
        if (to || rx.size() != 8 || gets.size() != 8) begin
            n_fail++;
            $display("FAIL bp_count: got rx=%0d gets=%0d timeout=%0d want 8/8/0", rx.size(), gets.size(), to);
        end
        for (int k = 0; k < expq.size() && k < rx.size(); k++) begin
            n_cmp++;
            if (rx[k].d !== expq[k].d || rx[k].l !== expq[k].l) begin
                n_fail++;
                $display("FAIL bp_byte[%0d]: got d=%h l=%b want d=%h l=%b", k, rx[k].d, rx[k].l, expq[k].d, expq[k].l);
            end
        end
        n_cmp++;
        if (stab_viol != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_viol);
        end
        $display("backpressure: %0d bytes delivered", rx.size());
    endtask

    task automatic test_round_robin();
        bit to;
        for (int rep = 0; rep < 2; rep++) begin
            clear();
            load(0, 3, 8'h30 + 8'(rep * 16), 1'b0, 1'b0);
            load(1, 2, 8'h40 + 8'(rep * 16), 1'b0, 1'b0);
            build_expected(2'b11);
            wait_rx(5, 40, to);
            run(3);
            n_cmp++;
            if (to || rx.size() != 5 || rx[0].ep !== 4'd1) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got rx=%0d first_ep=%0d want 5 bytes ep1 first", rep, rx.size(),
                         (rx.size() > 0) ? rx[0].ep : 4'hF);
            end
            for (int k = 0; k < expq.size() && k < rx.size(); k++) begin
                n_cmp++;
                if (rx[k].d !== expq[k].d || rx[k].ep !== expq[k].ep || rx[k].l !== expq[k].l) begin
                    n_fail++;
                    $display("FAIL rr_byte[%0d.%0d]: got d=%h ep=%0d l=%b want d=%h ep=%0d l=%b", rep, k,
                             rx[k].d, rx[k].ep, rx[k].l, expq[k].d, expq[k].ep, expq[k].l);
                end
            end
            for (int i = 1; i < gets.size(); i++) begin
                if (gets[i].e != gets[i-1].e) begin
                    n_cmp++;
                    if (gets[i].c - gets[i-1].c < 2) begin
                        n_fail++;
                        $display("FAIL rr_gap[%0d]: got %0d cycles want >=2", rep, gets[i].c - gets[i-1].c);
                    end
                end
            end
            $display("round_robin[%0d]: %0d bytes, first ep %0d", rep, rx.size(), (rx.size() > 0) ? rx[0].ep : 4'hF);
        end
    endtask

    task automatic test_setup_enable();
        bit to;
        clear();
        ep_enable = 2'b01;
        load(1, 8, 8'h50, 1'b1, 1'b0);
        run(12);
        n_cmp++;
        if (rx.size() != 0 || gets.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL en_masked: got rx=%0d gets=%0d busy=%b want 0/0/0", rx.size(), gets.size(), busy);
        end
        build_expected(2'b10);
        ep_enable = 2'b11;
        run(4);
        ep_enable = 2'b01;
        wait_rx(8, 40, to);
        run(3);
        n_cmp++;
        if (to || rx.size() != 8) begin
            n_fail++;
            $display("FAIL en_count: got rx=%0d timeout=%0d want 8/0", rx.size(), to);
        end
        for (int k = 0; k < expq.size() && k < rx.size(); k++) begin
            n_cmp++;
            if (rx[k].d !== expq[k].d || rx[k].ep !== 4'd1 || rx[k].s !== 1'b1 || rx[k].l !== expq[k].l) begin
                n_fail++;
                $display("FAIL en_byte[%0d]: got d=%h ep=%0d s=%b l=%b want d=%h ep=1 s=1 l=%b", k,
                         rx[k].d, rx[k].ep, rx[k].s, rx[k].l, expq[k].d, expq[k].l);
            end
        end
        ep_enable = 2'b11;
        $display("setup_enable: %0d setup bytes from ep1", rx.size());
    endtask

    task automatic test_reset_mid();
        bit to;
        clear();
        load(0, 8, 8'h60, 1'b0, 1'b0);
        wait_rx(3, 20, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL rmid_start: got %0d bytes want 3", rx.size());
        end
        reset_n   = 1'b0;
        pe_len[0] = pe_ptr[0];
        tick();
        n_cmp++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || get !== '0) begin
            n_fail++;
            $display("FAIL rmid_flush: got valid=%b busy=%b get=%b want 0/0/0", dout_valid, busy, get);
        end
        run(2);
        reset_n  = 1'b1;
        model_rr = N - 1;
        run(12);
        n_cmp++;
        if (rx.size() != 3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_spurious: got rx=%0d busy=%b want 3/0", rx.size(), busy);
        end
        $display("reset_mid: %0d bytes total", rx.size());
    endtask

    task automatic test_random();
        bit         to;
        bit [N-1:0] has;
        int         h;
        for (int r = 0; r < 8; r++) begin
            clear();
            h   = $urandom_range(1, 3);
            has = h[N-1:0];
            for (int e = 0; e < N; e++)
                if (has[e]) load(e, $urandom_range(1, 8), 8'h00, 1'($urandom_range(0, 1)), 1'b1);
            build_expected(has);
            rnd_ready = 1'b1;
            wait_rx(expq.size(), 200, to);
            rnd_ready  = 1'b0;
            want_ready = 1'b1;
            run(4);
            n_cmp++;
            if (to || rx.size() != expq.size() || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_count[%0d]: got rx=%0d busy=%b want %0d/0", r, rx.size(), busy, expq.size());
            end
            for (int k = 0; k < expq.size() && k < rx.size(); k++) begin
                n_cmp++;
                if (rx[k].d !== expq[k].d || rx[k].ep !== expq[k].ep || rx[k].s !== expq[k].s ||
                    rx[k].l !== expq[k].l) begin
                    n_fail++;
                    $display("FAIL rand_byte[%0d.%0d]: got d=%h ep=%0d s=%b l=%b want d=%h ep=%0d s=%b l=%b",
                             r, k, rx[k].d, rx[k].ep, rx[k].s, rx[k].l, expq[k].d, expq[k].ep, expq[k].s, expq[k].l);
                end
            end
            $display("random[%0d]: eps=%b bytes=%0d", r, has, rx.size());
        end
        n_cmp++;
        if (stab_viol != 0 || multi_viol != 0 || under_viol != 0) begin
            n_fail++;
            $display("FAIL protocol: got stable=%0d multihot=%0d bad_get=%0d want 0/0/0", stab_viol, multi_viol, under_viol);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        ep_enable  = 2'b11;
        dout_ready = 1'b1;
        for (int e = 0; e < N; e++) begin
            pe_setup[e]  = 1'b0;
            pkt_setup[e] = 1'b0;
        end
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_setup_enable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
